multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control sequencer for the multi-cycle MIPS datapath. Walks each instruction through
//  fetch/decode/execute/memory/writeback and drives every datapath mux select and write enable
//  (IorD, ALUSrcA/B, PCSrc, RegDst, MemtoReg). Holds state on a memory ready/req handshake,
//  and traps illegal opcodes and memory timeouts into a sticky error state.
// PARAMETERS
//  TIMEOUT   15  max consecutive cycles waiting for mem_ready in one memory state before ERR
//  CNT_W     4   width of wait counter; TIMEOUT must be <= 2**CNT_W-1
// PORTS
//  clk           in   1  system clock, all state updates on rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  opcode        in   6  instr[31:26] from instruction register
//  zero          in   1  ALU zero flag (valid in BEQEX)
//  mem_ready     in   1  memory completes the current access this cycle
//  mem_req       out  1  memory access request, held until mem_ready
//  mem_write     out  1  access is a write (valid with mem_req)
//  iord          out  1  0=PC, 1=ALUOut as memory address
//  ir_write      out  1  load instruction register
//  reg_dst       out  1  0=rt, 1=rd write address
//  mem_to_reg    out  1  0=ALUOut, 1=MDR write data
//  reg_write     out  1  register file write enable
//  alu_src_a     out  1  0=PC, 1=reg A
//  alu_src_b     out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2
//  alu_op        out  2  00=add, 01=sub, 10=decode funct
//  pc_src        out  2  00=ALU result, 01=ALUOut, 10=jump target
//  pc_en         out  1  PC load = pc_write | (branch & zero)
//  err           out  1  sticky error flag
// BEHAVIOUR
//  - States: INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BEQEX, ADDIEX,
//    ADDIWB, JEX, ERR. 4-bit encoding, constants in package.
//  - Async reset -> INIT, wait counter 0; INIT: all outputs 0 (incl. mem_req, err); next FETCH.
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and
//    pc_en asserted only in the cycle mem_ready=1; then -> DECODE. Else stay.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode:
//    100011/101011->MEMADR, 000000->RTEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, other->ERR.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEMRD, sw->MEMWR.
//  - MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB. MEMWB: reg_write=1, reg_dst=0,
//    mem_to_reg=1 -> FETCH.
//  - MEMWR: mem_req=1, mem_write=1, iord=1; on mem_ready -> FETCH.
//  - RTEX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTWB: reg_write=1, reg_dst=1,
//    mem_to_reg=0 -> FETCH.
//  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero -> FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB: reg_write=1, reg_dst=0,
//    mem_to_reg=0 -> FETCH.
//  - JEX: pc_src=10, pc_en=1 -> FETCH.
//  - Unlisted outputs 0 in every state (no latches; default-assign all outputs).
//  - Wait counter: clears on entry to any memory state and on mem_ready; increments each cycle
//    in FETCH/MEMRD/MEMWR with mem_ready=0. When counter==TIMEOUT and mem_ready=0 -> ERR.
//    mem_ready on the TIMEOUT cycle wins (access completes normally).
//  - ERR: err=1, all enables/mem_req 0; sticky until rst_n low.
//  - Reset mid-access: mem_req drops asynchronously; no ir_write/reg_write/pc_en can fire.
//  - Latency without waits: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
// STRUCTURE
//  - Package mips_ctrl_pkg: state localparams, opcode constants (OP_RTYPE, OP_LW, OP_SW,
//    OP_BEQ, OP_ADDI, OP_J), alu_src_b/pc_src/alu_op encodings; shared with datapath/ALU decoder.
//  - One sub-module: mem_wait_timer (counter + timeout compare, params TIMEOUT/CNT_W).
//  - FSM: one sequential state register + combinational next-state/output block.
// TESTING
//  1. Reset, mem_ready tied 1, opcode=100011 -> INIT,FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1,
//     mem_to_reg=1 on cycle 6; ir_write and pc_en on cycle 2 only.
//  2. opcode=000100, zero=1 then zero=0 -> BEQEX pc_src=01, pc_en=1 then 0; back to FETCH.
//  3. FETCH with mem_ready low 5 cycles -> mem_req held 6 cycles, ir_write only on 6th, no ERR.
//  4. MEMRD with mem_ready low 16 cycles (TIMEOUT=15) -> ERR, err=1, all enables 0; mem_ready
//     at counter==15 instead -> normal MEMWB.
//  5. opcode=111111 in DECODE -> ERR, sticky across 20 cycles; rst_n pulse -> INIT, err=0.
//  6. rst_n low mid-MEMWR with mem_ready=0 -> mem_req/mem_write drop same cycle; INIT next.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes and
// datapath mux select values used by the controller, datapath and ALU decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,
        S_BEQEX  = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JEX    = 4'd12,
        S_ERR    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags the cycle
// on which the access has waited TIMEOUT cycles without completing.
module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Held at zero outside memory states, so every access starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!active || ready) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A completing access on the limit cycle is not a timeout.
    assign timeout = active && !ready && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through its states,
// drives datapath selects/enables, and traps illegal opcodes and memory timeouts.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       err
);

    state_t state, next;
    logic   timeout;
    logic   pc_write;
    logic   branch;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (is_mem_state(state)),
        .ready   (mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else        state <= next;
    end

    always_comb begin
        next       = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        err        = 1'b0;

        case (state)
            S_INIT: next = S_FETCH;

            // PC+4 computed while the instruction is read.
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    next     = S_DECODE;
                end else if (timeout) begin
                    next = S_ERR;
                end
            end

            // Branch target speculatively computed into ALUOut.
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_RTEX;
                    OP_BEQ:       next = S_BEQEX;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_J:         next = S_JEX;
                    default:      next = S_ERR;
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OP_LW)      next = S_MEMRD;
                else if (opcode == OP_SW) next = S_MEMWR;
                else                      next = S_ERR;
            end

            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)    next = S_MEMWB;
                else if (timeout) next = S_ERR;
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next       = S_FETCH;
            end

            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready)    next = S_FETCH;
                else if (timeout) next = S_ERR;
            end

            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                next      = S_RTWB;
            end

            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                next      = S_FETCH;
            end

            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                next      = S_FETCH;
            end

            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                next      = S_ADDIWB;
            end

            S_ADDIWB: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end

            S_JEX: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                next     = S_FETCH;
            end

            S_ERR: err = 1'b1;

            default: next = S_ERR;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: latency/count vector table, directed corner sequences,
// and random instruction streams checked against a step-queue reference model.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, err;
    logic [1:0] alu_src_b, alu_op, pc_src;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req, wr, iord, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       pce, err;
    } outs_t;

    outs_t act;
    assign act = {mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, pc_en, err};

    typedef enum int {K_INIT, K_FETCH, K_DEC, K_ADR, K_RD, K_RWB, K_WR, K_RTEX, K_RTWB,
                      K_BEQ, K_AEX, K_AWB, K_J, K_ERR} kind_t;

    // Expected outputs of each instruction step, straight from the control table.
    function automatic outs_t exp_out(input kind_t k, input logic rdy, input logic z);
        outs_t o;
        o = '0;
        case (k)
            K_FETCH: begin o.req = 1; o.asb = 2'b01; o.irw = rdy; o.pce = rdy; end
            K_DEC:   o.asb = 2'b11;
            K_ADR:   begin o.asa = 1; o.asb = 2'b10; end
            K_RD:    begin o.req = 1; o.iord = 1; end
            K_RWB:   begin o.rw = 1; o.m2r = 1; end
            K_WR:    begin o.req = 1; o.wr = 1; o.iord = 1; end
            K_RTEX:  begin o.asa = 1; o.aop = 2'b10; end
            K_RTWB:  begin o.rw = 1; o.rdst = 1; end
            K_BEQ:   begin o.asa = 1; o.aop = 2'b01; o.pcs = 2'b01; o.pce = z; end
            K_AEX:   begin o.asa = 1; o.asb = 2'b10; end
            K_AWB:   o.rw = 1;
            K_J:     begin o.pcs = 2'b10; o.pce = 1; end
            K_ERR:   o.err = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Called at a falling edge: drive, sample 1 time unit later, move to next falling edge.
    task automatic step(input kind_t k, input logic rdy, input string nm);
        mem_ready = rdy;
        #1;
        chk(nm, 32'(act), 32'(exp_out(k, rdy, zero)));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic legal(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         lat, rw, pce, mw;
        string      nm;
    } vec_t;

    vec_t  tbl[7];
    kind_t q[$];

    initial begin
        tbl[0] = '{6'b100011, 1'b0, 5, 1, 1, 0, "vec_lw"};
        tbl[1] = '{6'b101011, 1'b0, 4, 0, 1, 1, "vec_sw"};
        tbl[2] = '{6'b000000, 1'b0, 4, 1, 1, 0, "vec_rtype"};
        tbl[3] = '{6'b001000, 1'b0, 4, 1, 1, 0, "vec_addi"};
        tbl[4] = '{6'b000100, 1'b1, 3, 0, 2, 0, "vec_beq_taken"};
        tbl[5] = '{6'b000100, 1'b0, 3, 0, 1, 0, "vec_beq_not"};
        tbl[6] = '{6'b000010, 1'b0, 3, 0, 2, 0, "vec_j"};

        // Instruction period between fetches and per-instruction enable counts.
        foreach (tbl[v]) begin
            int t1, t2, rw, pce, mw;
            do_reset();
            opcode = tbl[v].op;
            zero   = tbl[v].z;
            t1 = -1; t2 = -1; rw = 0; pce = 0; mw = 0;
            for (int c = 0; c < 24 && t2 < 0; c++) begin
                mem_ready = 1'b1;
                #1;
                if (ir_write) begin
                    if (t1 < 0) t1 = c;
                    else        t2 = c;
                end
                if (t1 >= 0 && t2 < 0) begin
                    rw  += int'(reg_write);
                    pce += int'(pc_en);
                    mw  += int'(mem_write & mem_req);
                end
                @(negedge clk);
            end
            if (t2 < 0) t2 = t1 - 1;
            chk(tbl[v].nm, {8'(t2 - t1), 8'(rw), 8'(pce), 8'(mw)},
                {8'(tbl[v].lat), 8'(tbl[v].rw), 8'(tbl[v].pce), 8'(tbl[v].mw)});
        end

        // lw with no waits, cycle by cycle from reset.
        do_reset();
        opcode = 6'b100011; zero = 1'b0;
        step(K_INIT,  1, "t1_init");
        step(K_FETCH, 1, "t1_fetch");
        step(K_DEC,   1, "t1_decode");
        step(K_ADR,   1, "t1_memadr");
        step(K_RD,    1, "t1_memrd");
        step(K_RWB,   1, "t1_memwb");

        // beq taken then not taken.
        opcode = 6'b000100; zero = 1'b1;
        step(K_FETCH, 1, "t2_fetch_a");
        step(K_DEC,   1, "t2_decode_a");
        step(K_BEQ,   1, "t2_beq_taken");
        zero = 1'b0;
        step(K_FETCH, 1, "t2_fetch_b");
        step(K_DEC,   1, "t2_decode_b");
        step(K_BEQ,   1, "t2_beq_not");

        // Fetch stretched by five wait cycles.
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) step(K_FETCH, 0, "t3_fetch_wait");
        step(K_FETCH, 1, "t3_fetch_done");
        step(K_DEC,   1, "t3_decode");
        step(K_RTEX,  1, "t3_rtex");
        step(K_RTWB,  1, "t3_rtwb");

        // MEMRD: sixteen not-ready cycles time out.
        opcode = 6'b100011;
        step(K_FETCH, 1, "t4_fetch");
        step(K_DEC,   1, "t4_decode");
        step(K_ADR,   1, "t4_memadr");
        for (int i = 0; i < 16; i++) step(K_RD, 0, "t4_rd_wait");
        step(K_ERR, 0, "t4_err");
        step(K_ERR, 1, "t4_err_hold");

        // Completion on the limit cycle wins over the timeout.
        do_reset();
        step(K_INIT,  1, "t4b_init");
        step(K_FETCH, 1, "t4b_fetch");
        step(K_DEC,   1, "t4b_decode");
        step(K_ADR,   1, "t4b_memadr");
        for (int i = 0; i < 15; i++) step(K_RD, 0, "t4b_rd_wait");
        step(K_RD,  1, "t4b_rd_last");
        step(K_RWB, 1, "t4b_memwb");

        // Illegal opcode traps and stays trapped until reset.
        opcode = 6'b111111;
        step(K_FETCH, 1, "t5_fetch");
        step(K_DEC,   1, "t5_decode");
        for (int i = 0; i < 20; i++) step(K_ERR, logic'(i[0]), "t5_sticky");
        do_reset();
        step(K_INIT, 1, "t5_after_rst");

        // Reset asserted in the middle of a store.
        opcode = 6'b101011;
        step(K_FETCH, 1, "t6_fetch");
        step(K_DEC,   1, "t6_decode");
        step(K_ADR,   1, "t6_memadr");
        step(K_WR,    0, "t6_memwr");
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_drop", 32'(act), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(K_INIT, 1, "t6_init");

        // Random instruction streams against a queue-of-steps reference model.
        begin
            int    w, errc;
            logic  slow, rdy;
            kind_t k;
            do_reset();
            q.delete();
            q.push_back(K_INIT);
            w = 0; errc = 0; slow = 1'b0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (q.size() == 0) begin
                    int r;
                    logic [5:0] op;
                    r = int'($urandom_range(0, 15));
                    slow = ($urandom_range(0, 9) == 0);
                    q.push_back(K_FETCH);
                    q.push_back(K_DEC);
                    if (r <= 2)       begin op = 6'b100011; q.push_back(K_ADR); q.push_back(K_RD); q.push_back(K_RWB); end
                    else if (r <= 5)  begin op = 6'b101011; q.push_back(K_ADR); q.push_back(K_WR); end
                    else if (r <= 8)  begin op = 6'b000000; q.push_back(K_RTEX); q.push_back(K_RTWB); end
                    else if (r <= 10) begin op = 6'b000100; q.push_back(K_BEQ); end
                    else if (r <= 12) begin op = 6'b001000; q.push_back(K_AEX); q.push_back(K_AWB); end
                    else if (r <= 14) begin op = 6'b000010; q.push_back(K_J); end
                    else begin
                        op = 6'($urandom);
                        while (legal(op)) op = 6'($urandom);
                        q.push_back(K_ERR);
                    end
                    opcode = op;
                end
                k = q[0];
                rdy = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
                zero = 1'($urandom);
                mem_ready = rdy;
                #1;
                chk("rand", 32'(act), 32'(exp_out(k, rdy, zero)));
                if (k == K_FETCH || k == K_RD || k == K_WR) begin
                    if (rdy) begin
                        void'(q.pop_front());
                        w = 0;
                    end else if (w == 15) begin
                        q.delete();
                        q.push_back(K_ERR);
                    end else begin
                        w++;
                    end
                end else if (k != K_ERR) begin
                    void'(q.pop_front());
                end
                if (k == K_ERR && ++errc == 6) begin
                    errc = 0;
                    w = 0;
                    q.delete();
                    q.push_back(K_INIT);
                    do_reset();
                end else begin
                    @(negedge clk);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
